// File: rtl/instr_fetch_sequencer.sv
// Fetch/dispatch sequencer: reads the ROM at the PC, hands each word to the decoder, then steps or loads the PC.
// Optional macro FETCH_BOUND_CHK_EN: a fetch at or above PROG_DEPTH stops the program with a sticky err.
module instr_fetch_sequencer #(
   parameter int         ADDR_W     = 6,
   parameter int         DATA_W     = 32,
   parameter int         PROG_DEPTH = 48,
   parameter logic [5:0] OPC_JMP    = 6'h3E,
   parameter logic [5:0] OPC_END    = 6'h3F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] instruction_address,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              pc_en,
   output logic              pc_inc,
   output logic              pc_w_en,
   output logic [DATA_W-1:0] pc_data,
   output logic              pc_complete,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_DISPATCH, S_ADVANCE, S_SETTLE, S_DONE
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic              imem_rd_q;
   logic [DATA_W-1:0] instr_q;
   logic              instr_valid_q;
   logic              pc_en_q;
   logic              pc_inc_q;
   logic              pc_w_en_q;
   logic [DATA_W-1:0] pc_data_q;
   logic              pc_complete_q;
   logic              busy_q;
   logic              done_q;
   logic              addr_oob;
   logic [5:0]        data_opc;
   logic [5:0]        instr_opc;

   assign data_opc  = imem_data[DATA_W-1 -: 6];
   assign instr_opc = instr_q[DATA_W-1 -: 6];

`ifdef FETCH_BOUND_CHK_EN
   localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(PROG_DEPTH);
   logic err_q;
   // The read strobe is registered on FETCH entry, so the bound is judged on the live PC here.
   assign addr_oob = (instruction_address >= DEPTH_L);
   assign err      = err_q;
`else
   logic unused_depth;
   assign unused_depth = ^PROG_DEPTH;
   assign addr_oob     = 1'b0;
   assign err          = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         imem_addr_q   <= '0;
         imem_rd_q     <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_inc_q      <= 1'b0;
         pc_w_en_q     <= 1'b0;
         pc_data_q     <= '0;
         pc_complete_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
`ifdef FETCH_BOUND_CHK_EN
         err_q         <= 1'b0;
`endif
      end else begin
         imem_rd_q     <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_inc_q      <= 1'b0;
         pc_w_en_q     <= 1'b0;
         pc_complete_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_FETCH;
                  imem_addr_q <= instruction_address;
                  imem_rd_q   <= !addr_oob;
                  busy_q      <= 1'b1;
               end
            end
            S_FETCH: begin
`ifdef FETCH_BOUND_CHK_EN
               if (imem_addr_q >= DEPTH_L) begin
                  state_q       <= S_DONE;
                  err_q         <= 1'b1;
                  pc_complete_q <= 1'b1;
                  pc_en_q       <= 1'b1;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
               end else
`endif
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (data_opc == OPC_END) begin
                  state_q       <= S_DONE;
                  pc_complete_q <= 1'b1;
                  pc_en_q       <= 1'b1;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
               end else begin
                  state_q       <= S_DISPATCH;
                  instr_q       <= imem_data;
                  instr_valid_q <= 1'b1;
               end
            end
            S_DISPATCH: begin
               // The PC pulse is registered on the handshake edge, so it lands in ADVANCE.
               if (instr_ready) begin
                  state_q       <= S_ADVANCE;
                  instr_valid_q <= 1'b0;
                  pc_en_q       <= 1'b1;
                  if (instr_opc == OPC_JMP) begin
                     pc_w_en_q <= 1'b1;
                     pc_data_q <= {{(DATA_W-ADDR_W){1'b0}}, instr_q[ADDR_W-1:0]};
                  end else begin
                     pc_inc_q  <= 1'b1;
                  end
               end
            end
            S_ADVANCE: state_q <= S_SETTLE;
            S_SETTLE: begin
               state_q     <= S_FETCH;
               imem_addr_q <= instruction_address;
               imem_rd_q   <= !addr_oob;
            end
            S_DONE:  state_q <= S_DONE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign imem_addr   = imem_addr_q;
   assign imem_rd     = imem_rd_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc_en       = pc_en_q;
   assign pc_inc      = pc_inc_q;
   assign pc_w_en     = pc_w_en_q;
   assign pc_data     = pc_data_q;
   assign pc_complete = pc_complete_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus random programs checked against a program-level model.
module tb_instr_fetch_sequencer;

`ifdef FETCH_BOUND_CHK_EN
   localparam bit BOUND = 1'b1;
`else
   localparam bit BOUND = 1'b0;
`endif
   localparam logic [31:0] W_END = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        instr_ready = 1'b0;
   logic [5:0]  instruction_address;
   logic [5:0]  imem_addr;
   logic        imem_rd;
   logic [31:0] imem_data = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        pc_en, pc_inc, pc_w_en, pc_complete, busy, done, err;
   logic [31:0] pc_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .instruction_address(instruction_address),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc_en(pc_en), .pc_inc(pc_inc), .pc_w_en(pc_w_en), .pc_data(pc_data),
      .pc_complete(pc_complete), .busy(busy), .done(done), .err(err)
   );

   // Neighbouring blocks: the program counter and a synchronous ROM.
   logic [5:0]  pc = '0;
   logic        pc_load = 1'b0;
   logic [5:0]  pc_load_val = '0;
   logic [31:0] rom [64];
   assign instruction_address = pc;

   always @(posedge clk) begin
      if (pc_load)      pc <= pc_load_val;
      else if (pc_w_en) pc <= pc_data[5:0];
      else if (pc_inc)  pc <= pc + 6'd1;
   end

   always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

   // Cycle monitor: records transfers, reads and pulses; flags protocol breaches.
   logic [31:0] obs_q [$];
   logic [5:0]  rd_q [$];
   int inc_cnt = 0, wen_cnt = 0, cmp_cnt = 0, pcen_bad = 0, stab_bad = 0;
   logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
   logic [31:0] pi = '0;

   always @(negedge clk) begin
      if (instr_valid && instr_ready) obs_q.push_back(instr);
      if (imem_rd) rd_q.push_back(imem_addr);
      if (pc_inc === 1'b1)      inc_cnt <= inc_cnt + 1;
      if (pc_w_en === 1'b1)     wen_cnt <= wen_cnt + 1;
      if (pc_complete === 1'b1) cmp_cnt <= cmp_cnt + 1;
      if (pc_en !== (pc_inc | pc_w_en | pc_complete)) pcen_bad <= pcen_bad + 1;
      if (pv && !pr && !prst && (instr_valid !== 1'b1 || instr !== pi)) stab_bad <= stab_bad + 1;
      pv   <= instr_valid;
      pr   <= instr_ready;
      prst <= rst;
      pi   <= instr;
   end

   int b_inc, b_wen, b_cmp, b_obs, b_rd;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_inc = inc_cnt; b_wen = wen_cnt; b_cmp = cmp_cnt;
      b_obs = obs_q.size(); b_rd = rd_q.size();
   endtask

   task automatic reset_dut();
      rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic load_pc(input logic [5:0] v);
      pc_load_val = v; pc_load = 1'b1;
      tick();
      pc_load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rand_ready);
      for (int n = 0; n < budget && done !== 1'b1; n++) begin
         if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, budget);
      end
   endtask

   // Program-level reference: walk the ROM from pc0 the way the program is meant to execute.
   logic [31:0] exp_q [$];
   logic [5:0]  exp_rd [$];
   int exp_inc, exp_jmp;
   bit exp_err;

   function automatic void model_run(input logic [5:0] pc0);
      logic [5:0]  p;
      logic [31:0] w;
      p = pc0;
      exp_q.delete(); exp_rd.delete();
      exp_inc = 0; exp_jmp = 0; exp_err = 1'b0;
      for (int s = 0; s < 200; s++) begin
         if (BOUND && p >= 6'd48) begin exp_err = 1'b1; break; end
         exp_rd.push_back(p);
         w = rom[p];
         if (w[31:26] == 6'h3F) break;
         exp_q.push_back(w);
         if (w[31:26] == 6'h3E) begin exp_jmp++; p = w[5:0]; end
         else begin exp_inc++; p = p + 6'd1; end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({imem_addr, imem_rd, instr, instr_valid, pc_en, pc_inc, pc_w_en, pc_data,
           pc_complete, busy, done, err} !== 79'd0) begin
         errors++;
         $display("FAIL reset_outputs: got instr_valid=%b busy=%b done=%b imem_rd=%b pc_en=%b, required all 0",
                  instr_valid, busy, done, imem_rd, pc_en);
      end
      rst = 1'b0;
   endtask

   task automatic test_seq_end();
      reset_dut();
      rom[0] = 32'h0000_0011; rom[1] = W_END;
      load_pc(6'd0);
      instr_ready = 1'b1;
      snap();
      pulse_start();
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 6'd0) begin
         errors++; $display("FAIL fetch0: rd=%b addr=%0d, required rd=1 addr=0", imem_rd, imem_addr);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL wait_state: valid=%b busy=%b, required 0/1", instr_valid, busy);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0000_0011) begin
         errors++; $display("FAIL dispatch: valid=%b instr=%h, required 1/00000011", instr_valid, instr);
      end
      tick();
      checks++;
      if (pc_inc !== 1'b1 || pc_en !== 1'b1 || pc_w_en !== 1'b0) begin
         errors++; $display("FAIL inc_pulse: inc=%b en=%b wen=%b, required 1/1/0", pc_inc, pc_en, pc_w_en);
      end
      tick(); tick();
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 6'd1) begin
         errors++; $display("FAIL fetch1_5cyc: rd=%b addr=%0d, required rd=1 addr=1", imem_rd, imem_addr);
      end
      tick(); tick();
      checks++;
      if (pc_complete !== 1'b1 || pc_en !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL complete: cmp=%b en=%b done=%b busy=%b, required 1/1/1/0",
                            pc_complete, pc_en, done, busy);
      end
      tick();
      checks++;
      if (pc_complete !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL done_sticky: cmp=%b done=%b, required 0/1", pc_complete, done);
      end
      checks++;
      if (obs_q.size() - b_obs != 1 || obs_q[b_obs] !== 32'h0000_0011) begin
         errors++; $display("FAIL one_transfer: %0d transfers, required 1 of 00000011", obs_q.size() - b_obs);
      end
      checks++;
      if (inc_cnt - b_inc != 1 || cmp_cnt - b_cmp != 1 || wen_cnt - b_wen != 0 || err !== 1'b0) begin
         errors++; $display("FAIL seq_pulses: inc=%0d cmp=%0d wen=%0d err=%b, required 1/1/0/0",
                            inc_cnt - b_inc, cmp_cnt - b_cmp, wen_cnt - b_wen, err);
      end
   endtask

   task automatic test_jump();
      reset_dut();
      rom[2] = 32'hF800_0005; rom[5] = W_END;
      load_pc(6'd2);
      instr_ready = 1'b1;
      snap();
      pulse_start();
      for (int n = 0; n < 20 && pc_w_en !== 1'b1; n++) tick();
      checks++;
      if (pc_w_en !== 1'b1 || pc_data !== 32'h0000_0005 || pc_inc !== 1'b0 || pc_en !== 1'b1) begin
         errors++; $display("FAIL jmp_wen: wen=%b data=%h inc=%b, required 1/00000005/0", pc_w_en, pc_data, pc_inc);
      end
      tick();
      checks++;
      if (pc_w_en !== 1'b0) begin
         errors++; $display("FAIL jmp_one_cycle: wen=%b, required 0", pc_w_en);
      end
      for (int n = 0; n < 10 && imem_rd !== 1'b1; n++) tick();
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 6'd5) begin
         errors++; $display("FAIL jmp_target_fetch: rd=%b addr=%0d, required rd=1 addr=5", imem_rd, imem_addr);
      end
      wait_done(20, 1'b0);
      tick(); tick();
      checks++;
      if (obs_q.size() - b_obs != 1 || obs_q[b_obs] !== 32'hF800_0005 || inc_cnt != b_inc) begin
         errors++; $display("FAIL jmp_dispatched: %0d transfers, %0d incs, required 1 of F8000005 and 0",
                            obs_q.size() - b_obs, inc_cnt - b_inc);
      end
   endtask

   task automatic test_stall();
      reset_dut();
      rom[0] = 32'h0000_0022; rom[1] = W_END;
      load_pc(6'd0);
      instr_ready = 1'b0;
      snap();
      pulse_start();
      for (int n = 0; n < 10 && instr_valid !== 1'b1; n++) tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (instr_valid !== 1'b1 || instr !== 32'h0000_0022 || (pc_inc | pc_w_en) !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: valid=%b instr=%h inc=%b wen=%b, required 1/00000022/0/0",
                               k, instr_valid, instr, pc_inc, pc_w_en);
         end
      end
      instr_ready = 1'b1;
      tick();
      checks++;
      if (pc_inc !== 1'b1 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL stall_release: inc=%b valid=%b, required 1/0", pc_inc, instr_valid);
      end
      wait_done(20, 1'b0);
      tick(); tick();
      checks++;
      if (obs_q.size() - b_obs != 1) begin
         errors++; $display("FAIL stall_transfers: %0d, required 1", obs_q.size() - b_obs);
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      rom[3] = 32'h0000_0033; rom[4] = W_END;
      load_pc(6'd3);
      instr_ready = 1'b0;
      snap();
      pulse_start();
      for (int n = 0; n < 10 && instr_valid !== 1'b1; n++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({imem_addr, imem_rd, instr, instr_valid, pc_en, pc_inc, pc_w_en, pc_data,
           pc_complete, busy, done, err} !== 79'd0) begin
         errors++; $display("FAIL rst_mid_outputs: valid=%b busy=%b instr=%h, required all 0",
                            instr_valid, busy, instr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (obs_q.size() != b_obs || inc_cnt != b_inc || wen_cnt != b_wen) begin
         errors++; $display("FAIL rst_mid_no_pulse: transfers=%0d incs=%0d wens=%0d, required 0",
                            obs_q.size() - b_obs, inc_cnt - b_inc, wen_cnt - b_wen);
      end
      instr_ready = 1'b1;
      pulse_start();
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 6'd3) begin
         errors++; $display("FAIL restart_pc: rd=%b addr=%0d, required rd=1 addr=3", imem_rd, imem_addr);
      end
      wait_done(20, 1'b0);
      tick(); tick();
      checks++;
      if (obs_q.size() - b_obs != 1 || obs_q[b_obs] !== 32'h0000_0033) begin
         errors++; $display("FAIL restart_transfer: %0d transfers, required 1 of 00000033", obs_q.size() - b_obs);
      end
   endtask

   task automatic test_start_ignored();
      reset_dut();
      rom[6] = 32'h0000_0066; rom[7] = 32'h0000_0077; rom[8] = W_END;
      load_pc(6'd6);
      instr_ready = 1'b1;
      snap();
      start = 1'b1;
      wait_done(40, 1'b0);
      repeat (5) tick();
      start = 1'b0;
      checks++;
      if (rd_q.size() - b_rd != 3) begin
         errors++; $display("FAIL no_extra_rd: %0d reads, required 3", rd_q.size() - b_rd);
      end
      checks++;
      if (obs_q.size() - b_obs != 2 || cmp_cnt - b_cmp != 1 || done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL start_ignored: transfers=%0d cmp=%0d done=%b busy=%b, required 2/1/1/0",
                            obs_q.size() - b_obs, cmp_cnt - b_cmp, done, busy);
      end
   endtask

   task automatic test_bound();
      reset_dut();
      rom[50] = 32'h0000_0050; rom[51] = W_END;
      load_pc(6'd50);
      instr_ready = 1'b1;
      model_run(6'd50);
      snap();
      pulse_start();
      wait_done(30, 1'b0);
      tick(); tick();
      checks++;
      if (err !== exp_err) begin
         errors++; $display("FAIL bound_err: err=%b, required %b", err, exp_err);
      end
      checks++;
      if (rd_q.size() - b_rd != exp_rd.size() || obs_q.size() - b_obs != exp_q.size()) begin
         errors++; $display("FAIL bound_fetch: reads=%0d transfers=%0d, required %0d/%0d",
                            rd_q.size() - b_rd, obs_q.size() - b_obs, exp_rd.size(), exp_q.size());
      end
      checks++;
      if (cmp_cnt - b_cmp != 1) begin
         errors++; $display("FAIL bound_complete: %0d pulses, required 1", cmp_cnt - b_cmp);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      int pc0, len, a;
      for (int it = 0; it < 15; it++) begin
         reset_dut();
         for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] >= 6'h3E) w[31] = 1'b0;
            rom[i] = w;
         end
         pc0 = $urandom_range(0, 20);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            a = pc0 + i;
            if ($urandom_range(0, 4) == 0) begin
               w = $urandom; w[31:26] = 6'h3E; w[5:0] = 6'(a + 2);
               rom[a] = w;
            end
         end
         w = $urandom; w[31:26] = 6'h3F; rom[pc0 + len] = w;
         rom[pc0 + len + 1] = W_END;
         load_pc(6'(pc0));
         model_run(6'(pc0));
         snap();
         instr_ready = 1'($urandom_range(0, 1));
         pulse_start();
         wait_done(400, 1'b1);
         instr_ready = 1'b0;
         tick(); tick();
         checks++;
         if (obs_q.size() - b_obs != exp_q.size()) begin
            errors++; $display("FAIL rand%0d_count: %0d transfers, required %0d", it, obs_q.size() - b_obs, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && b_obs + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[b_obs + i] !== exp_q[i]) begin
               errors++; $display("FAIL rand%0d_instr%0d: got %h, required %h", it, i, obs_q[b_obs + i], exp_q[i]);
            end
         end
         checks++;
         if (rd_q.size() - b_rd != exp_rd.size()) begin
            errors++; $display("FAIL rand%0d_reads: %0d, required %0d", it, rd_q.size() - b_rd, exp_rd.size());
         end
         for (int i = 0; i < exp_rd.size() && b_rd + i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[b_rd + i] !== exp_rd[i]) begin
               errors++; $display("FAIL rand%0d_addr%0d: got %0d, required %0d", it, i, rd_q[b_rd + i], exp_rd[i]);
            end
         end
         checks++;
         if (inc_cnt - b_inc != exp_inc || wen_cnt - b_wen != exp_jmp || cmp_cnt - b_cmp != 1 || err !== exp_err) begin
            errors++; $display("FAIL rand%0d_pulses: inc=%0d wen=%0d cmp=%0d err=%b, required %0d/%0d/1/%b",
                               it, inc_cnt - b_inc, wen_cnt - b_wen, cmp_cnt - b_cmp, err, exp_inc, exp_jmp, exp_err);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = W_END;
      test_reset();
      test_seq_end();
      test_jump();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_bound();
      test_random();
      checks++;
      if (pcen_bad != 0) begin
         errors++; $display("FAIL pc_en_invariant: %0d cycles with pc_en mismatched, required 0", pcen_bad);
      end
      checks++;
      if (stab_bad != 0) begin
         errors++; $display("FAIL valid_stable: %0d cycles with instr dropped or changed, required 0", stab_bad);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
